// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared writeback result type and integer writeback port count
package wb_arbiter_pkg;

    localparam int INT_WBPORTS = 2;

    typedef struct packed {
        logic [7:0]  rob_idx;
        logic [3:0]  irob_idx;
        logic        use_imm;
        logic        rd_wen;
        logic [5:0]  iprd_idx;
        logic [31:0] result;
    } comwbInfo_t;

endpackage

// File: rtl/wb_rr_select.sv
// wb_rr_select: round-robin pick of up to NUM_WBPORT requesters starting at ptr_i
module wb_rr_select #(
    parameter int NUM_FU     = 4,
    parameter int NUM_WBPORT = 2,
    localparam int PW        = $clog2(NUM_FU)
) (
    input  logic [NUM_FU-1:0]     req_i,
    input  logic [PW-1:0]         ptr_i,
    output logic [NUM_WBPORT-1:0] port_vld_o,
    output logic [PW-1:0]         port_idx_o [NUM_WBPORT],
    output logic [NUM_FU-1:0]     granted_o,
    output logic [PW-1:0]         nxt_ptr_o
);

    localparam int CW = $clog2(NUM_WBPORT + 1);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic [CW-1:0] cnt;

    // scan from the pointer with wrap; the k-th requester found lands on port k
    always_comb begin
        port_vld_o = '0;
        port_idx_o = '{default: '0};
        granted_o  = '0;
        nxt_ptr_o  = ptr_i;
        sum        = '0;
        idx        = '0;
        cnt        = '0;
        for (int j = 0; j < NUM_FU; j++) begin
            sum = {1'b0, ptr_i} + (PW+1)'(j);
            idx = sum >= (PW+1)'(NUM_FU) ? PW'(sum - (PW+1)'(NUM_FU)) : sum[PW-1:0];
            if (req_i[idx] && cnt < CW'(NUM_WBPORT)) begin
                for (int k = 0; k < NUM_WBPORT; k++) begin
                    if (cnt == CW'(k)) begin
                        port_vld_o[k] = 1'b1;
                        port_idx_o[k] = idx;
                    end
                end
                granted_o[idx] = 1'b1;
                nxt_ptr_o      = idx == PW'(NUM_FU - 1) ? '0 : idx + 1'b1;
                cnt            = cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin grant of finished FU results onto registered writeback ports
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_FU     = 4,
    parameter int NUM_WBPORT = INT_WBPORTS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FU-1:0]     i_fu_finished,
    input  comwbInfo_t            i_comwbInfo [NUM_FU],
    output logic [NUM_FU-1:0]     o_wb_stall,
    output logic [NUM_WBPORT-1:0] o_wb_vld,
    output comwbInfo_t            o_wbInfo [NUM_WBPORT]
);

    localparam int PW = $clog2(NUM_FU);

    logic [PW-1:0]         rr_ptr_q;
    logic [PW-1:0]         rr_ptr_d;
    logic [NUM_WBPORT-1:0] port_vld;
    logic [PW-1:0]         port_idx [NUM_WBPORT];
    logic [NUM_FU-1:0]     granted;
    logic [NUM_WBPORT-1:0] wb_vld_q;
    comwbInfo_t            wb_info_d [NUM_WBPORT];
    comwbInfo_t            wb_info_q [NUM_WBPORT];

    wb_rr_select #(.NUM_FU(NUM_FU), .NUM_WBPORT(NUM_WBPORT)) u_sel (
        .req_i      (i_fu_finished),
        .ptr_i      (rr_ptr_q),
        .port_vld_o (port_vld),
        .port_idx_o (port_idx),
        .granted_o  (granted),
        .nxt_ptr_o  (rr_ptr_d)
    );

    assign o_wb_stall = i_fu_finished & ~granted;
    assign o_wb_vld   = wb_vld_q;
    assign o_wbInfo   = wb_info_q;

    // route each granted FU to its port; an empty port must never write the regfile
    always_comb begin
        for (int k = 0; k < NUM_WBPORT; k++) begin
            wb_info_d[k]        = i_comwbInfo[port_idx[k]];
            wb_info_d[k].rd_wen = port_vld[k] & i_comwbInfo[port_idx[k]].rd_wen;
        end
    end

    // pointer and writeback port registers, rewritten every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            wb_vld_q  <= '0;
            wb_info_q <= '{default: '0};
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wb_vld_q  <= port_vld;
            wb_info_q <= wb_info_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized scoreboard bench for wb_arbiter with directed corner cases
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int NF = 4;
    localparam int NP = 2;
    localparam int IB = $bits(comwbInfo_t);

    typedef struct packed {
        logic [NP-1:0]            vld;
        comwbInfo_t [NP-1:0]      info;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NF-1:0] fin = '0;
    logic [NF-1:0] stall;
    logic [NP-1:0] vld;
    comwbInfo_t    info_in [NF];
    comwbInfo_t    info_out [NP];

    wb_arbiter #(.NUM_FU(NF), .NUM_WBPORT(NP)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_fu_finished (fin),
        .i_comwbInfo   (info_in),
        .o_wb_stall    (stall),
        .o_wb_vld      (vld),
        .o_wbInfo      (info_out)
    );

    always #5 clk = ~clk;

    exp_t          q[$];
    int            errs = 0;
    int            checks = 0;
    logic [NF-1:0] pend = '0;
    comwbInfo_t    res [NF];
    int            mptr = 0;
    logic [7:0]    next_rob = '0;
    int            streak [NF];
    bit            seen [256];
    int            seen_ptr;
    int            gcnt [NF];
    int            outcnt = 0;
    exp_t          mon_e;
    comwbInfo_t    sav2, sav3;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic new_res(input int i);
        res[i].rob_idx  = next_rob;
        res[i].irob_idx = 4'($urandom);
        res[i].use_imm  = 1'($urandom);
        res[i].rd_wen   = 1'($urandom);
        res[i].iprd_idx = 6'($urandom);
        res[i].result   = $urandom;
        next_rob++;
        pend[i] = 1'b1;
    endtask

    // one arbitration cycle: drive FU state, predict grants from the scan rule, queue expected output
    task automatic cycle(input bit r);
        exp_t          e;
        int            order[$];
        logic [NF-1:0] gmask;
        @(posedge clk);
        #2;
        seen_ptr = int'(dut.rr_ptr_q);
        chk("rr_ptr", 64'(seen_ptr), 64'(mptr));
        rst = r;
        for (int i = 0; i < NF; i++) info_in[i] = r ? comwbInfo_t'(IB'({$urandom, $urandom})) : res[i];
        fin = r ? NF'($urandom) : pend;
        #1;
        e = '0;
        gmask = '0;
        if (!r) begin
            for (int j = 0; j < NF; j++)
                if (pend[(mptr + j) % NF] && order.size() < NP) order.push_back((mptr + j) % NF);
            foreach (order[k]) begin
                e.vld[k]  = 1'b1;
                e.info[k] = res[order[k]];
                gmask[order[k]] = 1'b1;
            end
            if (order.size() > 0) mptr = (order[order.size()-1] + 1) % NF;
            chk("stall", 64'(stall), 64'(pend & ~gmask));
            for (int i = 0; i < NF; i++) begin
                streak[i] = stall[i] ? streak[i] + 1 : 0;
                if (stall[i]) chk("starve", 64'(streak[i] < 2), 64'(1));
            end
            pend = pend & ~gmask;
        end else begin
            pend = '0;
            mptr = 0;
            for (int i = 0; i < NF; i++) streak[i] = 0;
        end
        q.push_back(e);
    endtask

    // monitor: compare each registered writeback against the oldest queued expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk("wb_vld", 64'(vld), 64'(mon_e.vld));
                for (int k = 0; k < NP; k++) begin
                    if (mon_e.vld[k]) begin
                        chk("wb_info", 64'(info_out[k]), 64'(mon_e.info[k]));
                        if (vld[k]) begin
                            chk("dup_rob", 64'(seen[info_out[k].rob_idx]), 64'(0));
                            seen[info_out[k].rob_idx] = 1'b1;
                            outcnt++;
                        end
                    end else begin
                        chk("idle_rd_wen", 64'(info_out[k].rd_wen), 64'(0));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NF; i++) begin
            res[i] = '0;
            info_in[i] = '0;
            streak[i] = 0;
            gcnt[i] = 0;
        end
        // reset held two cycles with random inputs
        cycle(1);
        cycle(1);
        // single result from FU2
        res[2] = '0;
        res[2].rob_idx = next_rob;
        next_rob++;
        res[2].rd_wen = 1'b1;
        res[2].iprd_idx = 6'd5;
        res[2].result = 32'h1234;
        pend[2] = 1'b1;
        cycle(0);
        chk("single_stall", 64'(stall), 64'(4'b0000));
        // wrap-around: pointer at 3, FU0 and FU3 finished
        new_res(0);
        new_res(3);
        sav2 = res[3];
        sav3 = res[0];
        cycle(0);
        chk("single_ptr", 64'(seen_ptr), 64'(3));
        chk("single_vld", 64'(vld), 64'(2'b01));
        chk("single_result", 64'(info_out[0].result), 64'h1234);
        chk("single_iprd", 64'(info_out[0].iprd_idx), 64'(5));
        chk("wrap_stall", 64'(stall), 64'(4'b0000));
        // lone FU3 brings the pointer back to 0
        new_res(3);
        cycle(0);
        chk("wrap_ptr", 64'(seen_ptr), 64'(1));
        chk("wrap_vld", 64'(vld), 64'(2'b11));
        chk("wrap_port0", 64'(info_out[0].rob_idx), 64'(sav2.rob_idx));
        chk("wrap_port1", 64'(info_out[1].rob_idx), 64'(sav3.rob_idx));
        // overload: all four finished at pointer 0
        for (int i = 0; i < NF; i++) new_res(i);
        sav2 = res[2];
        sav3 = res[3];
        cycle(0);
        chk("ovl_ptr0", 64'(seen_ptr), 64'(0));
        chk("ovl_stall_t", 64'(stall), 64'(4'b1100));
        cycle(0);
        chk("ovl_ptr1", 64'(seen_ptr), 64'(2));
        chk("ovl_stall_t1", 64'(stall), 64'(4'b0000));
        // sustained: every FU finished every cycle
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NF; i++) if (!pend[i]) new_res(i);
            cycle(0);
            if (c == 0) begin
                chk("ovl_ptr2", 64'(seen_ptr), 64'(0));
                chk("ovl_port0", 64'(info_out[0]), 64'(sav2));
                chk("ovl_port1", 64'(info_out[1]), 64'(sav3));
            end
            for (int i = 0; i < NF; i++) gcnt[i] += int'(fin[i] & ~stall[i]);
        end
        for (int i = 0; i < NF; i++) chk("sustain_grants", 64'(gcnt[i]), 64'(4));
        // mid-operation reset while stalled results are pending
        cycle(1);
        new_res(1);
        new_res(3);
        cycle(0);
        chk("midrst_ptr", 64'(seen_ptr), 64'(0));
        chk("midrst_vld", 64'(vld), 64'(2'b00));
        // randomized traffic with occasional resets
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < NF; i++) if (!pend[i] && $urandom_range(1, 0) == 1) new_res(i);
            cycle($urandom_range(29, 0) == 0);
        end
        for (int c = 0; c < 4; c++) cycle(0);
        @(posedge clk);
        #2;
        chk("drain_empty", 64'(q.size()), 64'(0));
        chk("drain_pend", 64'(pend), 64'(0));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the integer function units and the shared writeback ports of the register file, ROB and bypass network. Each cycle it collects finished results (`fu_finished` + `comwbInfo_t`) from `NUM_FU` units and grants at most `NUM_WBPORT` of them in round-robin order. It registers the granted results onto the writeback ports and drives a per-FU `wb_stall` back to every unit that was not granted. A stalled FU freezes its output registers and retries the next cycle.

## Interface
- `NUM_FU`, default 4: number of FU result inputs (≥2).
- `NUM_WBPORT`, default 2: number of writeback ports (1 ≤ `NUM_WBPORT` ≤ `NUM_FU`).
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `i_fu_finished`  in  `[NUM_FU]`  FU i holds a valid result; it stays asserted and its data stays stable while `o_wb_stall[i]` is high.
- `i_comwbInfo`  in  `comwbInfo_t [NUM_FU]`  result: `rob_idx`, `irob_idx`, `use_imm`, `rd_wen`, `iprd_idx`, `result`.
- `o_wb_stall`  out  `[NUM_FU]`  combinational; high means FU i was not granted this cycle and must hold.
- `o_wb_vld`  out  `[NUM_WBPORT]`  registered; the writeback port carries a completed instruction.
- `o_wbInfo`  out  `comwbInfo_t [NUM_WBPORT]`  registered granted result.

## Operation
- Every finished FU consumes a slot, including results with `rd_wen=0` (ROB completion still needed).
- Round-robin pointer `rr_ptr` (`$clog2(NUM_FU)` bits, reset 0):
  - Scan FU indices `rr_ptr`, `rr_ptr+1`, … modulo `NUM_FU`.
  - The first `NUM_WBPORT` FUs with `i_fu_finished=1` are granted, in scan order.
  - The k-th granted FU goes to port k.
- `o_wb_stall[i] = i_fu_finished[i] && !granted[i]`. Idle FUs see stall 0.
- Pointer update:
  - If any FU is granted, `rr_ptr <= (last granted index + 1) mod NUM_FU`, with wrap-around.
  - If none is granted, `rr_ptr` holds.
- Output register, written every cycle:
  - `o_wb_vld[k] <= (port k granted)`.
  - `o_wbInfo[k] <=` the granted FU's info.
  - For an ungranted port, `o_wbInfo[k].rd_wen <= 0`; its other fields are don't-care.
- Starvation bound: a finished FU is granted within `ceil(NUM_FU/NUM_WBPORT)` cycles.
- No downstream backpressure: the regfile/ROB accept every port every cycle.
- Reset values:
  - `o_wb_vld` all 0.
  - `o_wbInfo[*].rd_wen` = 0.
  - `rr_ptr` = 0.
  - `o_wb_stall` follows its combinational definition.
- Reset mid-operation:
  - Registered outputs clear on the next edge.
  - Any results pending in FUs are discarded by the FUs' own reset.

## Timing
- Latency: FU result granted in cycle t appears on `o_wb_vld`/`o_wbInfo` in cycle t+1.
- `o_wb_stall` is same-cycle combinational from `i_fu_finished` and `rr_ptr`. It has no dependence on `o_wb_*`, so there is no comb loop with FUs whose `fu_finished` is a register.
- A granted FU sees stall 0 and advances at the same edge the arbiter captures its data. No duplicate or lost result is allowed.
- Throughput: `NUM_WBPORT` results per cycle, sustained.

## Structure
- `comwbInfo_t` comes from the shared core package. No new typedefs are needed there.
- Optional package constant: default `NUM_WBPORT` for integer writeback.
- One natural combinational sub-module, `wb_rr_select`:
  - Inputs: request vector and `rr_ptr`.
  - Outputs: per-port one-hot/index grants, `granted` vector, next pointer.
- `wb_arbiter` holds `rr_ptr`, the output registers and the data muxing.

## Test plan
All scenarios use `NUM_FU=4`, `NUM_WBPORT=2`.
- Reset: hold `rst` 2 cycles with random inputs → `o_wb_vld=00`, `o_wbInfo[*].rd_wen=0`; after release, `rr_ptr=0`.
- Single result: FU2 finished with `result=0x1234`, `iprd_idx=5`, `rd_wen=1` → `o_wb_stall=0000`; next cycle `o_wb_vld=01`, port0 `result=0x1234`, `iprd_idx=5`; `rr_ptr=3`.
- Overload: all 4 FUs finished at `rr_ptr=0` →
  - Cycle t: FU0→port0, FU1→port1, `stall=1100` (FU3..FU0), `rr_ptr→2`.
  - Cycle t+1: FU2→port0, FU3→port1, `rr_ptr→0`.
  - FU2 and FU3 data are unchanged between t and t+1.
- Wrap-around: `rr_ptr=3`, FU0 and FU3 finished → port0=FU3, port1=FU0, `stall=0000`, `rr_ptr→1`.
- Sustained: all FUs finish every cycle for 8 cycles → each FU granted exactly 4 times, no FU stalled 2 consecutive cycles, 16 results out, no duplicate `rob_idx`.
- Mid-op reset: assert `rst` while FU1 and FU3 are stalled → next cycle `o_wb_vld=00`, `rr_ptr=0`.
